vram_arbiter: RTL and testbench

- Sits between the video scanout fetcher and CPU data port (upstream) and the external video SRAM pins (downstream).
- Arbitrates the two requesters and issues pipelined read bursts and single-word read/write cycles.
- Drives v_adr/v_we/v_oe_sram/v_oe_pin/v_dat_o and consumes board-registered read data on v_dat_i.
- Runs entirely in the clk_vga domain; CPU-side signals arrive already synchronised.

---
 rtl/vram_arbiter.sv | 169 ++++++++++++++++
 tb/tb_vram_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : vram_arbiter
// Brief    : Arbitrates video burst fetches and CPU word accesses onto one
//            pipelined external video SRAM.
// Revision : 1.0 - initial release
//==============================================================================
module vram_arbiter #(
  parameter int ADDR_W    = 17,
  parameter int DATA_W    = 16,
  parameter int VID_BURST = 8
) (
  input  logic              clk_vga,
  input  logic              rst,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_adr,
  output logic              vid_ack,
  output logic [DATA_W-1:0] vid_dat,
  output logic              vid_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_adr,
  input  logic [DATA_W-1:0] cpu_dat_i,
  output logic [DATA_W-1:0] cpu_dat_o,
  output logic              cpu_ack,
  output logic [ADDR_W-1:0] v_adr,
  output logic              v_we,
  output logic              v_oe_sram,
  output logic              v_oe_pin,
  output logic [DATA_W-1:0] v_dat_o,
  input  logic [DATA_W-1:0] v_dat_i
);

  localparam int CNT_W = $clog2(VID_BURST);
  localparam logic [CNT_W-1:0] c_LAST_BEAT = CNT_W'(VID_BURST - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_VID   = 3'd1,
    S_CRD   = 3'd2,
    S_CWAIT = 3'd3,
    S_WR0   = 3'd4,
    S_WR1   = 3'd5,
    S_WR2   = 3'd6,
    S_TURN  = 3'd7
  } state_t;

  state_t           r_state;
  logic             r_last_cpu;
  logic [CNT_W-1:0] r_beat;
  logic             r_p1_vld;
  logic             r_p1_vid;

  logic w_last_beat;
  logic w_arb;
  logic w_vid_pend;
  logic w_cpu_pend;
  logic w_pick_vid;
  logic w_pick_cpu;

  // A requester still sees its own ack this cycle, so it is not yet withdrawn.
  assign w_vid_pend  = vid_req & ~vid_ack;
  assign w_cpu_pend  = cpu_req & ~cpu_ack;
  assign w_pick_vid  = w_vid_pend & (~w_cpu_pend | r_last_cpu);
  assign w_pick_cpu  = w_cpu_pend & (~w_vid_pend | ~r_last_cpu);
  assign w_last_beat = (r_state == S_VID) && (r_beat == c_LAST_BEAT);
  assign w_arb       = (r_state == S_IDLE) || (r_state == S_TURN) || w_last_beat;

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_last_cpu <= 1'b1;
      r_beat     <= '0;
      r_p1_vld   <= 1'b0;
      r_p1_vid   <= 1'b0;
      vid_ack    <= 1'b0;
      vid_dat    <= '0;
      vid_valid  <= 1'b0;
      cpu_dat_o  <= '0;
      cpu_ack    <= 1'b0;
      v_adr      <= '0;
      v_we       <= 1'b0;
      v_oe_sram  <= 1'b0;
      v_oe_pin   <= 1'b0;
      v_dat_o    <= '0;
    end else begin
      vid_ack   <= 1'b0;
      vid_valid <= 1'b0;
      cpu_ack   <= 1'b0;

      // Address cycle N -> board register N+1 -> delivered to requester N+2.
      r_p1_vld <= (r_state == S_VID) || (r_state == S_CRD);
      r_p1_vid <= (r_state == S_VID);
      if (r_p1_vld) begin
        if (r_p1_vid) begin
          vid_valid <= 1'b1;
          vid_dat   <= v_dat_i;
        end else begin
          cpu_ack   <= 1'b1;
          cpu_dat_o <= v_dat_i;
        end
      end

      case (r_state)
        S_VID: begin
          if (w_last_beat) begin
            v_oe_sram <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            v_adr  <= v_adr + ADDR_W'(1);
            r_beat <= r_beat + CNT_W'(1);
          end
        end
        S_CRD: begin
          v_oe_sram <= 1'b0;
          r_state   <= S_CWAIT;
        end
        S_CWAIT: r_state <= S_IDLE;
        S_WR0: begin
          v_we    <= 1'b1;
          r_state <= S_WR1;
        end
        S_WR1: begin
          v_we    <= 1'b0;
          cpu_ack <= 1'b1;
          r_state <= S_WR2;
        end
        S_WR2: begin
          v_oe_pin <= 1'b0;
          r_state  <= S_TURN;
        end
        default: begin
          v_we      <= 1'b0;
          v_oe_pin  <= 1'b0;
          v_oe_sram <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase

      if (w_arb) begin
        if (w_pick_vid) begin
          r_state    <= S_VID;
          r_last_cpu <= 1'b0;
          r_beat     <= '0;
          v_adr      <= vid_adr;
          v_oe_sram  <= 1'b1;
          vid_ack    <= 1'b1;
        end else if (w_pick_cpu && !cpu_we) begin
          r_state    <= S_CRD;
          r_last_cpu <= 1'b1;
          v_adr      <= cpu_adr;
          v_oe_sram  <= 1'b1;
        end else if (w_pick_cpu && (r_state == S_VID)) begin
          // Bus turnaround first; the write is re-granted on TURN exit.
          r_state <= S_TURN;
        end else if (w_pick_cpu) begin
          r_state    <= S_WR0;
          r_last_cpu <= 1'b1;
          v_adr      <= cpu_adr;
          v_dat_o    <= cpu_dat_i;
          v_oe_pin   <= 1'b1;
          v_we       <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : tb_vram_arbiter
// Brief    : Scoreboard bench for vram_arbiter with an SRAM board model.
// Revision : 1.0 - initial release
//==============================================================================
module tb_vram_arbiter;

  localparam int AW    = 17;
  localparam int DW    = 16;
  localparam int BURST = 8;

  logic          clk_vga = 1'b0;
  logic          rst;
  logic          vid_req;
  logic [AW-1:0] vid_adr;
  logic          vid_ack;
  logic [DW-1:0] vid_dat;
  logic          vid_valid;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_adr;
  logic [DW-1:0] cpu_dat_i;
  logic [DW-1:0] cpu_dat_o;
  logic          cpu_ack;
  logic [AW-1:0] v_adr;
  logic          v_we;
  logic          v_oe_sram;
  logic          v_oe_pin;
  logic [DW-1:0] v_dat_o;
  logic [DW-1:0] v_dat_i = '0;

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .VID_BURST(BURST)) dut (
    .clk_vga(clk_vga), .rst(rst),
    .vid_req(vid_req), .vid_adr(vid_adr), .vid_ack(vid_ack),
    .vid_dat(vid_dat), .vid_valid(vid_valid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr),
    .cpu_dat_i(cpu_dat_i), .cpu_dat_o(cpu_dat_o), .cpu_ack(cpu_ack),
    .v_adr(v_adr), .v_we(v_we), .v_oe_sram(v_oe_sram), .v_oe_pin(v_oe_pin),
    .v_dat_o(v_dat_o), .v_dat_i(v_dat_i)
  );

  always #5 clk_vga = ~clk_vga;

  int unsigned cyc = 0;
  always @(posedge clk_vga) cyc <= cyc + 1;

  // Board: SRAM array plus the data register in front of the FPGA.
  logic [DW-1:0] sram    [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  always @(posedge clk_vga) begin
    if (v_we) sram[v_adr] <= v_dat_o;
    v_dat_i <= v_oe_sram ? sram[v_adr] : '0;
  end

  typedef struct { logic [DW-1:0] d; int unsigned c; } vexp_t;
  typedef struct { bit we; logic [DW-1:0] d; } cexp_t;
  vexp_t         vid_q[$];
  cexp_t         cpu_q[$];
  logic [AW-1:0] adr_q[$];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_vga); #1;
    end
  endtask

  task automatic issue_vid(input logic [AW-1:0] a, output int unsigned ack_c, output int unsigned lat);
    bit got;
    int unsigned t0;
    logic [AW-1:0] ai;
    got = 0; ack_c = 0; t0 = cyc;
    vid_adr = a;
    vid_req = 1'b1;
    for (int k = 0; k < 400 && !got; k++) begin
      @(posedge clk_vga); #1;
      if (vid_ack) begin
        got = 1; ack_c = cyc;
        adr_q.push_back(a);
        for (int i = 0; i < BURST; i++) begin
          vexp_t e;
          ai  = a + AW'(i);
          e.d = ref_mem[ai];
          e.c = cyc + 2 + i;
          vid_q.push_back(e);
        end
      end
    end
    vid_req = 1'b0;
    lat = ack_c - t0;
    chk(got, "vid_ack_timeout", int'(got), 1);
  endtask

  task automatic issue_cpu(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           output int unsigned ack_c, output int unsigned lat);
    bit got;
    int unsigned t0;
    cexp_t e;
    got = 0; ack_c = 0; t0 = cyc;
    e.we = we;
    e.d  = we ? d : ref_mem[a];
    cpu_q.push_back(e);
    cpu_we = we; cpu_adr = a; cpu_dat_i = d;
    cpu_req = 1'b1;
    for (int k = 0; k < 400 && !got; k++) begin
      @(posedge clk_vga); #1;
      if (cpu_ack) begin
        got = 1; ack_c = cyc;
        if (we) ref_mem[a] = d;
      end
    end
    cpu_req = 1'b0;
    lat = ack_c - t0;
    chk(got, "cpu_ack_timeout", int'(got), 1);
  endtask

  task automatic do_reset();
    vid_req = 1'b0; cpu_req = 1'b0;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  // Monitor: compares every DUT presentation against the queues and checks bus rules.
  logic          prev_rst = 1'b0, prev_pin = 1'b0, prev_oe = 1'b0, prev_we = 1'b0;
  logic [AW-1:0] prev_adr = '0, base = '0;
  logic [DW-1:0] prev_do = '0;
  bit            trk = 0, turn_chk = 0, cpu_pend_va = 0, cpu_served = 0;
  int            idx = 0, we_cnt = 0;

  initial begin : monitor
    forever begin
      @(posedge clk_vga); #2;
      if (prev_rst && !rst)
        chk({vid_ack, vid_valid, cpu_ack, v_we, v_oe_sram, v_oe_pin} == 6'b0 && vid_dat == '0 &&
            cpu_dat_o == '0 && v_adr == '0 && v_dat_o == '0, "reset_outputs",
            int'({vid_ack, vid_valid, cpu_ack, v_we, v_oe_sram, v_oe_pin}), 0);
      if (!rst) begin
        chk(!(v_we && v_oe_sram), "we_vs_oe", int'({v_we, v_oe_sram}), 0);
        chk(!(v_oe_pin && v_oe_sram), "pin_vs_oe", int'({v_oe_pin, v_oe_sram}), 0);
        chk(!(vid_ack && cpu_ack), "ack_overlap", int'({vid_ack, cpu_ack}), 0);
        if (v_we) begin
          chk(prev_pin && v_oe_pin && !prev_we, "we_only_wr1", int'({prev_pin, v_oe_pin, prev_we}), 6);
          we_cnt++;
        end
        if (prev_pin && v_oe_pin)
          chk(v_adr == prev_adr && v_dat_o == prev_do, "wr_adr_stable", int'(v_adr), int'(prev_adr));
        if (v_oe_pin && !prev_pin) chk(!prev_oe, "turn_rd_to_wr", int'(prev_oe), 0);
        if (v_oe_sram && !prev_oe) chk(!prev_pin, "turn_wr_to_rd", int'(prev_pin), 0);
        if (turn_chk) begin
          chk(!v_oe_pin && !v_oe_sram && !v_we, "turn_cycle", int'({v_oe_pin, v_oe_sram, v_we}), 0);
          turn_chk = 0;
        end
        if (cpu_ack) begin
          cpu_served = 1;
          chk(cpu_q.size() > 0, "cpu_ack_unexpected", int'(cpu_ack), 0);
          if (cpu_q.size() > 0) begin
            cexp_t e;
            e = cpu_q.pop_front();
            if (e.we) begin
              chk(we_cnt == 1, "we_pulse_count", we_cnt, 1);
              chk(v_oe_pin, "wr2_pin_held", int'(v_oe_pin), 1);
              turn_chk = 1;
            end else begin
              chk(cpu_dat_o == e.d, "cpu_rd_data", int'(cpu_dat_o), int'(e.d));
            end
          end
          we_cnt = 0;
        end
        if (vid_ack) begin
          chk(!trk, "burst_too_short", idx, BURST);
          chk(!(cpu_pend_va && !cpu_served), "back_to_back_bursts", int'(cpu_pend_va), 0);
          cpu_pend_va = cpu_req;
          cpu_served  = 0;
          chk(adr_q.size() > 0, "vid_ack_unexpected", int'(vid_ack), 0);
          if (adr_q.size() > 0) base = adr_q.pop_front();
          chk(v_adr == base && v_oe_sram, "vid_first_adr", int'(v_adr), int'(base));
          trk = 1; idx = 1;
        end else if (trk) begin
          chk(v_adr == base + AW'(idx) && v_oe_sram, "vid_burst_adr", int'(v_adr), int'(base + AW'(idx)));
          idx++;
          if (idx == BURST) trk = 0;
        end
        if (vid_valid) begin
          chk(vid_q.size() > 0, "vid_valid_unexpected", int'(vid_valid), 0);
          if (vid_q.size() > 0) begin
            vexp_t e;
            e = vid_q.pop_front();
            chk(vid_dat == e.d, "vid_data", int'(vid_dat), int'(e.d));
            chk(cyc == e.c, "vid_valid_cycle", int'(cyc), int'(e.c));
          end
        end
      end else begin
        vid_q.delete(); cpu_q.delete(); adr_q.delete();
        trk = 0; turn_chk = 0; we_cnt = 0; cpu_pend_va = 0; cpu_served = 0;
      end
      prev_rst = rst; prev_pin = v_oe_pin; prev_oe = v_oe_sram; prev_we = v_we;
      prev_adr = v_adr; prev_do = v_dat_o;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  int unsigned va, ca, lv, lc, stop_c;
  int unsigned vacks[4];

  initial begin : stim
    for (int i = 0; i < (1 << AW); i++) begin
      sram[i]    = DW'(i * 40503) ^ 16'h5A5A;
      ref_mem[i] = sram[i];
    end
    for (int i = 0; i < BURST; i++) begin
      logic [AW-1:0] pa;
      pa = 17'h1FFFC + AW'(i);
      sram[pa]    = 16'hA000 + DW'(i);
      ref_mem[pa] = sram[pa];
    end
    vid_req = 0; vid_adr = '0; cpu_req = 0; cpu_we = 0; cpu_adr = '0; cpu_dat_i = '0;
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(2);

    // Wrapping burst
    issue_vid(17'h1FFFC, va, lv);
    chk(lv == 1, "vid_grant_latency", int'(lv), 1);
    idle(14);

    // Write then read back through a turnaround
    issue_cpu(1'b1, 17'h00123, 16'hBEEF, ca, lc);
    chk(lc == 3, "wr_latency", int'(lc), 3);
    issue_cpu(1'b0, 17'h00123, 16'h0000, ca, lc);
    chk(lc == 4, "rd_after_wr_latency", int'(lc), 4);
    idle(4);
    issue_cpu(1'b0, 17'h00123, 16'h0000, ca, lc);
    chk(lc == 3, "rd_latency", int'(lc), 3);
    idle(4);

    // Simultaneous requests after reset: video first, CPU right after the burst
    do_reset();
    fork
      issue_vid(17'h00040, va, lv);
      issue_cpu(1'b0, 17'h00123, 16'h0000, ca, lc);
    join
    chk(ca == va + BURST + 2, "cpu_after_burst", int'(ca - va), BURST + 2);
    idle(4);

    // Continuous video plus CPU writes: grants alternate
    fork
      for (int k = 0; k < 4; k++) issue_vid(AW'(17'h00400 + 17'(k * BURST)), vacks[k], lv);
      for (int k = 0; k < 3; k++) issue_cpu(1'b1, AW'(17'h00800 + 17'(k)), DW'(16'hC000 + k), ca, lc);
    join
    chk(vacks[1] - vacks[0] == BURST + 5, "alternate_gap", int'(vacks[1] - vacks[0]), BURST + 5);
    idle(12);

    // Reset on the 4th address of a burst
    issue_vid(17'h00200, va, lv);
    idle(3);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(12);
    issue_vid(17'h00300, va, lv);
    issue_cpu(1'b0, 17'h00800, 16'h0000, ca, lc);
    idle(12);

    // Random mixed traffic around the wrap point
    stop_c = cyc + 10000;
    fork
      while (cyc < stop_c) begin
        int unsigned a, b;
        idle($urandom_range(0, 20));
        issue_vid(17'h1FFE8 + AW'($urandom_range(0, 48)), a, b);
      end
      while (cyc < stop_c) begin
        int unsigned a, b;
        idle($urandom_range(0, 6));
        issue_cpu(1'($urandom_range(0, 1)), 17'h1FFF0 + AW'($urandom_range(0, 40)),
                  DW'($urandom), a, b);
      end
    join
    idle(20);
    chk(vid_q.size() == 0, "vid_q_drained", vid_q.size(), 0);
    chk(cpu_q.size() == 0, "cpu_q_drained", cpu_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
